// File: rtl/dec_gpr_bank_file_if.sv
// rtl/dec_gpr_bank_file_if.sv - read/write/bank-switch bus for the decode GPR bank file
interface dec_gpr_bank_file_if #(
    parameter int NRD   = 4,
    parameter int NWR   = 3,
    parameter int DEPTH = 32,
    parameter int WIDTH = 32,
    parameter int BANKS = 2,
    parameter int AW    = $clog2(DEPTH),
    parameter int BW    = $clog2(BANKS)
);
    logic [NRD-1:0]            rden;
    logic [NRD-1:0][AW-1:0]    raddr;
    logic [NRD-1:0][WIDTH-1:0] rd;
    logic [NWR-1:0]            wen;
    logic [NWR-1:0][AW-1:0]    waddr;
    logic [NWR-1:0][WIDTH-1:0] wd;
    logic                      bank_sw_req;
    logic [BW-1:0]             bank_sw_id;
    logic                      bank_sw_wipe;
    logic                      bank_sw_ack;
    logic [BW-1:0]             bank_id;
    logic                      busy;
    logic                      wr_conflict;

    modport master (
        output rden, raddr, wen, waddr, wd, bank_sw_req, bank_sw_id, bank_sw_wipe,
        input  rd, bank_sw_ack, bank_id, busy, wr_conflict
    );

    modport slave (
        input  rden, raddr, wen, waddr, wd, bank_sw_req, bank_sw_id, bank_sw_wipe,
        output rd, bank_sw_ack, bank_id, busy, wr_conflict
    );
endinterface

// File: rtl/dec_gpr_bank_file.sv
// rtl/dec_gpr_bank_file.sv - multi-bank GPR file with bank switch, wipe and write-conflict flag
module dec_gpr_bank_file #(
    parameter int NRD   = 4,
    parameter int NWR   = 3,
    parameter int DEPTH = 32,
    parameter int WIDTH = 32,
    parameter int BANKS = 2,
    parameter int AW    = $clog2(DEPTH),
    parameter int BW    = $clog2(BANKS)
) (
    input  logic                clk,
    input  logic                rst_l,
    input  logic                scan_mode,
    dec_gpr_bank_file_if.slave  bus
);
    typedef enum logic {IDLE, WIPE} state_t;

    state_t        state;
    logic [BW-1:0] bank_q;
    logic [BW-1:0] old_bank;
    logic [AW-1:0] wipe_ptr;
    logic          conflict_q;
    logic          collide;
    logic          sw_ack;
    logic          sw_go;

    logic [WIDTH-1:0] mem    [BANKS][DEPTH-1:1];
    logic             ent_we [BANKS][DEPTH-1:1];
    logic [WIDTH-1:0] ent_wd [BANKS][DEPTH-1:1];

    // scan_mode only matters to the clock-gate cells inserted on the per-entry enables
    logic unused_scan;
    assign unused_scan = scan_mode;

    assign sw_ack = bus.bank_sw_req && (state == IDLE);
    assign sw_go  = sw_ack && (bus.bank_sw_id != bank_q);

    // Ascending port order lets the highest-numbered port overwrite lower ones
    always_comb begin
        for (int b = 0; b < BANKS; b++) begin
            for (int e = 1; e < DEPTH; e++) begin
                ent_we[b][e] = 1'b0;
                ent_wd[b][e] = '0;
            end
        end
        for (int p = 0; p < NWR; p++) begin
            if (bus.wen[p] && (bus.waddr[p] != '0)) begin
                ent_we[bank_q][bus.waddr[p]] = 1'b1;
                ent_wd[bank_q][bus.waddr[p]] = bus.wd[p];
            end
        end
        if ((state == WIPE) && (wipe_ptr != '0)) begin
            ent_we[old_bank][wipe_ptr] = 1'b1;
            ent_wd[old_bank][wipe_ptr] = '0;
        end
    end

    always_comb begin
        collide = 1'b0;
        for (int i = 0; i < NWR; i++) begin
            for (int j = i + 1; j < NWR; j++) begin
                if (bus.wen[i] && bus.wen[j] && (bus.waddr[i] == bus.waddr[j]) &&
                    (bus.waddr[i] != '0)) begin
                    collide = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            bus.rd[p] = (bus.rden[p] && (bus.raddr[p] != '0)) ? mem[bank_q][bus.raddr[p]] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int b = 0; b < BANKS; b++) begin
                for (int e = 1; e < DEPTH; e++) begin
                    mem[b][e] <= '0;
                end
            end
        end else begin
            for (int b = 0; b < BANKS; b++) begin
                for (int e = 1; e < DEPTH; e++) begin
                    if (ent_we[b][e]) begin
                        mem[b][e] <= ent_wd[b][e];
                    end
                end
            end
        end
    end

    // Switches are only accepted in IDLE, so old_bank never equals the active bank while wiping
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state      <= IDLE;
            bank_q     <= '0;
            old_bank   <= '0;
            wipe_ptr   <= '0;
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= collide;
            case (state)
                IDLE: begin
                    if (sw_go) begin
                        bank_q <= bus.bank_sw_id;
                        if (bus.bank_sw_wipe) begin
                            old_bank <= bank_q;
                            wipe_ptr <= AW'(1);
                            state    <= WIPE;
                        end
                    end
                end
                WIPE: begin
                    wipe_ptr <= wipe_ptr + 1'b1;
                    if (wipe_ptr == AW'(DEPTH - 1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.bank_sw_ack = sw_ack;
    assign bus.bank_id     = bank_q;
    assign bus.busy        = (state == WIPE);
    assign bus.wr_conflict = conflict_q;
endmodule

// File: tb/tb_dec_gpr_bank_file.sv
// tb/tb_dec_gpr_bank_file.sv - randomized and directed bench for dec_gpr_bank_file against a reference model
module tb_dec_gpr_bank_file;
    logic clk = 1'b0;
    logic rst_l;
    logic scan_mode;
    int   n_cmp = 0;
    int   n_bad = 0;

    dec_gpr_bank_file_if #(.NRD(4), .NWR(3), .DEPTH(32), .WIDTH(32), .BANKS(2)) bus();
    dec_gpr_bank_file_if #(.NRD(2), .NWR(1), .DEPTH(16), .WIDTH(64), .BANKS(4)) bus2();

    dec_gpr_bank_file #(.NRD(4), .NWR(3), .DEPTH(32), .WIDTH(32), .BANKS(2)) dut (
        .clk(clk), .rst_l(rst_l), .scan_mode(scan_mode), .bus(bus)
    );
    dec_gpr_bank_file #(.NRD(2), .NWR(1), .DEPTH(16), .WIDTH(64), .BANKS(4)) dut2 (
        .clk(clk), .rst_l(rst_l), .scan_mode(scan_mode), .bus(bus2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: plain arrays plus a queue of addresses still to be wiped
    logic [31:0] m_mem [2][32];
    int          m_bank;
    int          m_old;
    bit          m_conf;
    int          wq[$];
    logic [31:0] exp_rd;
    bit          busy_now;
    bit          conf;
    int          wa;

    always @(negedge clk) begin
        if (!rst_l) begin
            for (int b = 0; b < 2; b++)
                for (int a = 0; a < 32; a++) m_mem[b][a] = '0;
            m_bank = 0;
            m_old  = 0;
            m_conf = 0;
            wq.delete();
        end
        for (int p = 0; p < 4; p++) begin
            exp_rd = (bus.rden[p] && bus.raddr[p] != 0) ? m_mem[m_bank][bus.raddr[p]] : 32'h0;
            chk($sformatf("model_rd%0d", p), bus.rd[p], exp_rd);
        end
        chk("model_ack", bus.bank_sw_ack, bus.bank_sw_req && (wq.size() == 0));
        chk("model_bank_id", bus.bank_id, m_bank);
        chk("model_busy", bus.busy, wq.size() != 0);
        chk("model_conflict", bus.wr_conflict, m_conf);
        if (rst_l) begin
            busy_now = (wq.size() != 0);
            conf = 0;
            for (int i = 0; i < 3; i++)
                for (int j = i + 1; j < 3; j++)
                    if (bus.wen[i] && bus.wen[j] && bus.waddr[i] == bus.waddr[j] && bus.waddr[i] != 0)
                        conf = 1;
            for (int p = 0; p < 3; p++)
                if (bus.wen[p] && bus.waddr[p] != 0) m_mem[m_bank][bus.waddr[p]] = bus.wd[p];
            if (busy_now) begin
                wa = wq.pop_front();
                m_mem[m_old][wa] = '0;
            end
            if (bus.bank_sw_req && !busy_now && int'(bus.bank_sw_id) != m_bank) begin
                if (bus.bank_sw_wipe) begin
                    m_old = m_bank;
                    for (int a = 1; a < 32; a++) wq.push_back(a);
                end
                m_bank = int'(bus.bank_sw_id);
            end
            m_conf = conf;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rden = '0; bus.raddr = '0; bus.wen = '0; bus.waddr = '0; bus.wd = '0;
        bus.bank_sw_req = 0; bus.bank_sw_id = '0; bus.bank_sw_wipe = 0;
        bus2.rden = '0; bus2.raddr = '0; bus2.wen = '0; bus2.waddr = '0; bus2.wd = '0;
        bus2.bank_sw_req = 0; bus2.bank_sw_id = '0; bus2.bank_sw_wipe = 0;
    endtask

    task automatic read_all(input string nm);
        for (int a = 0; a < 32; a++) begin
            bus.rden = 4'hF;
            for (int p = 0; p < 4; p++) bus.raddr[p] = 5'(a);
            @(negedge clk);
            chk(nm, bus.rd, 128'h0);
            cyc();
        end
        bus.rden = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst_l = 0;
        scan_mode = 0;
        idle();
        @(negedge clk);
        chk("rst_bank_id", bus.bank_id, 0);
        chk("rst_busy", bus.busy, 0);
        cyc();
        rst_l = 1;
        cyc();

        read_all("rst_rd");
        bus.wen = 3'b111;
        bus.wd  = {3{32'hFFFF_FFFF}};
        cyc();
        bus.wen = '0;
        bus.rden = 4'h1;
        bus.raddr[0] = 5'd0;
        @(negedge clk);
        chk("addr0_rd", bus.rd[0], 0);
        chk("addr0_conflict", bus.wr_conflict, 0);
        cyc();

        // Port 0 and port 2 collide on entry 5; port 2 must win
        bus.wen = 3'b101;
        bus.waddr[0] = 5'd5; bus.wd[0] = 32'hA5A5_0001;
        bus.waddr[2] = 5'd5; bus.wd[2] = 32'h5A5A_0002;
        cyc();
        bus.wen = '0;
        bus.rden = 4'h2;
        bus.raddr[1] = 5'd5;
        @(negedge clk);
        chk("conflict_rd", bus.rd[1], 32'h5A5A_0002);
        chk("conflict_pulse", bus.wr_conflict, 1);
        cyc();
        @(negedge clk);
        chk("conflict_one_cycle", bus.wr_conflict, 0);
        cyc();

        bus.wen = 3'b001; bus.waddr[0] = 5'd7; bus.wd[0] = 32'h1234;
        cyc();
        bus.wen = '0;
        bus.bank_sw_req = 1; bus.bank_sw_id = 1'b1; bus.bank_sw_wipe = 0;
        @(negedge clk);
        chk("sw1_ack", bus.bank_sw_ack, 1);
        cyc();
        bus.bank_sw_req = 0;
        bus.rden = 4'h1; bus.raddr[0] = 5'd7;
        @(negedge clk);
        chk("sw1_bank_id", bus.bank_id, 1);
        chk("sw1_rd7", bus.rd[0], 0);
        cyc();
        bus.bank_sw_req = 1; bus.bank_sw_id = 1'b0;
        cyc();
        bus.bank_sw_req = 0;
        @(negedge clk);
        chk("sw0_rd7", bus.rd[0], 32'h1234);
        cyc();

        for (int a = 1; a < 32; a++) begin
            bus.wen = 3'b001; bus.waddr[0] = 5'(a); bus.wd[0] = 32'(a << 8);
            cyc();
        end
        bus.wen = '0;
        bus.rden = 4'h1; bus.raddr[0] = 5'd31;
        bus.bank_sw_req = 1; bus.bank_sw_id = 1'b1; bus.bank_sw_wipe = 1;
        @(negedge clk);
        chk("fill_rd31", bus.rd[0], 32'h1F00);
        chk("wipe_sw_ack", bus.bank_sw_ack, 1);
        cyc();
        bus.bank_sw_req = 0; bus.rden = '0;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
            if (n == 3) begin
                chk("wipe_rd_new_bank", bus.rd[0], 32'hBEEF);
                chk("wipe_req_no_ack", bus.bank_sw_ack, 0);
            end
            cyc();
            if (n == 1) begin
                bus.wen = 3'b010; bus.waddr[1] = 5'd3; bus.wd[1] = 32'hBEEF;
            end else if (n == 2) begin
                bus.wen = '0;
                bus.rden = 4'h1; bus.raddr[0] = 5'd3;
                bus.bank_sw_req = 1; bus.bank_sw_id = 1'b0; bus.bank_sw_wipe = 0;
            end else if (n == 3) begin
                bus.bank_sw_req = 0; bus.rden = '0;
            end
        end
        chk("wipe_busy_len", n, 31);
        cyc();
        bus.bank_sw_req = 1; bus.bank_sw_id = 1'b0; bus.bank_sw_wipe = 0;
        @(negedge clk);
        chk("post_wipe_ack", bus.bank_sw_ack, 1);
        cyc();
        bus.bank_sw_req = 0;
        read_all("wiped_bank0");

        // Reset in the middle of a wipe
        bus.wen = 3'b001; bus.waddr[0] = 5'd4; bus.wd[0] = 32'h4444;
        cyc();
        bus.wen = '0;
        bus.bank_sw_req = 1; bus.bank_sw_id = 1'b1; bus.bank_sw_wipe = 1;
        cyc();
        bus.bank_sw_req = 0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
            cyc();
            if (n == 1) begin
                bus.wen = 3'b100; bus.waddr[2] = 5'd6; bus.wd[2] = 32'h6666;
            end else if (n == 2) begin
                bus.wen = '0;
            end else if (n == 10) begin
                rst_l = 0;
                break;
            end
        end
        @(negedge clk);
        chk("midwipe_rst_busy", bus.busy, 0);
        chk("midwipe_rst_bank", bus.bank_id, 0);
        cyc();
        rst_l = 1;
        cyc();
        read_all("rst_bank0");
        bus.bank_sw_req = 1; bus.bank_sw_id = 1'b1; bus.bank_sw_wipe = 0;
        cyc();
        bus.bank_sw_req = 0;
        read_all("rst_bank1");

        // Randomized traffic; the model process checks every cycle
        for (int i = 0; i < 2000; i++) begin
            bus.rden = 4'($urandom);
            for (int p = 0; p < 4; p++) bus.raddr[p] = 5'($urandom_range(0, 31));
            for (int p = 0; p < 3; p++) begin
                bus.wen[p]   = ($urandom_range(0, 2) == 0);
                bus.waddr[p] = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
                bus.wd[p]    = $urandom;
            end
            bus.bank_sw_req  = ($urandom_range(0, 9) == 0);
            bus.bank_sw_id   = 1'($urandom_range(0, 1));
            bus.bank_sw_wipe = 1'($urandom_range(0, 1));
            if (i == 1000) begin
                rst_l = 0;
                bus.bank_sw_req = 0;
            end else if (i == 1001) begin
                rst_l = 1;
            end
            cyc();
        end
        idle();
        cyc();

        // Alternate geometry: 2 read ports, 1 write port, 16 x 64-bit, 4 banks
        bus2.bank_sw_req = 1; bus2.bank_sw_id = 2'd3; bus2.bank_sw_wipe = 1;
        @(negedge clk);
        chk("d2_ack", bus2.bank_sw_ack, 1);
        cyc();
        bus2.bank_sw_req = 0;
        n = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!bus2.busy) break;
            n++;
            if (n == 1) chk("d2_bank_id", bus2.bank_id, 3);
            if (n == 3) chk("d2_rd64", bus2.rd[1], 64'hDEAD_BEEF_0123_4567);
            cyc();
            if (n == 1) begin
                bus2.wen = 1'b1; bus2.waddr[0] = 4'd9; bus2.wd[0] = 64'hDEAD_BEEF_0123_4567;
            end else if (n == 2) begin
                bus2.wen = '0;
                bus2.rden = 2'b10; bus2.raddr[1] = 4'd9;
            end
        end
        chk("d2_busy_len", n, 15);
        @(negedge clk);
        chk("d2_rd64_after", bus2.rd[1], 64'hDEAD_BEEF_0123_4567);
        cyc();
        idle();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
